data_receiver: RTL and testbench

Receive-side counterpart of the byte-serialising sender. Collects bytes strobed out of the UART receiver and reassembles them into one NUM_BYTES-wide word, first byte in the LSBs. Presents each complete word with a single-cycle valid pulse. An inter-byte gap timeout and the UART framing-error input resynchronise the link by discarding partial words.

---
 rtl/data_link_pkg.sv | 12 +
 rtl/gap_timer.sv | 31 +++
 rtl/data_receiver.sv | 116 +++++++++++
 tb/tb_data_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/data_link_pkg.sv
// Shared definitions for the byte-serial data link (sender and receiver sides).
package data_link_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_WORD_BYTES = 5;

    typedef enum logic {
        IDLE,
        COLLECT
    } rx_state_t;

endpackage

// File: rtl/gap_timer.sv
// Inactivity timer: counts enabled cycles since the last clear, saturating at TIMEOUT_CYCLES-1.
// Latency: expired follows the registered count combinationally.
// Backpressure: none; clear has priority over enable.
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/data_receiver.sv
// Reassembles UART rx bytes into NUM_BYTES-wide words, first byte in the LSBs.
// Latency: data_valid pulses 1 cycle after the strobe carrying the last byte.
// Backpressure: none; gap timeout or frame error discards a partial word and pulses resync.
module data_receiver
    import data_link_pkg::*;
#(
    parameter int NUM_BYTES      = DEFAULT_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BYTE_W-1:0]             byte_in,
    input  logic                          byte_valid,
    input  logic                          frame_error,
    output logic [NUM_BYTES*BYTE_W-1:0]   data_out,
    output logic                          data_valid,
    output logic                          busy,
    output logic                          resync
);

    localparam int              W        = NUM_BYTES * BYTE_W;
    localparam int              BCW      = $clog2(NUM_BYTES + 1);
    localparam logic [BCW-1:0]  LAST_IDX = BCW'(NUM_BYTES - 1);

    rx_state_t      state;
    rx_state_t      state_next;
    logic [W-1:0]   shreg;
    logic [W-1:0]   shift_in;
    logic [BCW-1:0] byte_cnt;
    logic           accept;
    logic           last_byte;
    logic           word_done;
    logic           gap_expired;
    logic           timeout_drop;
    logic           resync_next;

    generate
        if (NUM_BYTES == 1) begin : g_single
            assign shift_in = byte_in;
        end else begin : g_multi
            assign shift_in = {byte_in, shreg[W-1:BYTE_W]};
        end
    endgenerate

    // A frame error on the same edge poisons the byte, so it is never accepted.
    assign accept       = byte_valid && !frame_error;
    assign last_byte    = (byte_cnt == LAST_IDX);
    assign word_done    = accept && last_byte;
    assign timeout_drop = (state == COLLECT) && !byte_valid && !frame_error && gap_expired;
    assign resync_next  = frame_error ? ((state == COLLECT) || byte_valid) : timeout_drop;

    gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state != COLLECT) || byte_valid || frame_error),
        .enable  (state == COLLECT),
        .expired (gap_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !last_byte) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (frame_error || timeout_drop || word_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            resync     <= 1'b0;
        end else begin
            data_valid <= word_done;
            resync     <= resync_next;
            if (frame_error || timeout_drop) begin
                shreg    <= '0;
                byte_cnt <= '0;
            end else if (accept) begin
                shreg <= shift_in;
                if (last_byte) begin
                    byte_cnt <= '0;
                    data_out <= shift_in;
                end else begin
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver with NUM_BYTES=5, TIMEOUT_CYCLES=16.
module tb_data_receiver;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        frame_error;
    logic [39:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        resync;

    int n_chk  = 0;
    int n_fail = 0;

    data_receiver #(
        .NUM_BYTES      (5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_error (frame_error),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .resync      (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [7:0]  b;
        logic        fe;
        logic [39:0] exp_data;
        logic        exp_dv;
        logic        exp_busy;
        logic        exp_rs;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] b, input logic fe,
                                input logic [39:0] d, input logic dv, input logic bz,
                                input logic rs);
        vecs.push_back('{v, b, fe, d, dv, bz, rs});
    endfunction

    // seq lists the bytes in send order, first byte in the top 8 bits.
    function automatic void add_word(input logic [39:0] seq, input int gap,
                                     input logic [39:0] prev, input logic [39:0] word);
        logic last;
        for (int i = 0; i < 5; i++) begin
            last = (i == 4);
            add(1'b1, seq[39-8*i -: 8], 1'b0, last ? word : prev, last, !last, 1'b0);
            if (!last) begin
                for (int g = 0; g < gap; g++) add(1'b0, 8'h00, 1'b0, prev, 1'b0, 1'b1, 1'b0);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic fe);
        byte_valid  = v;
        byte_in     = b;
        frame_error = fe;
        @(posedge clk);
        #1;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [39:0] d, input logic dv,
                           input logic bz, input logic rs);
        chk({tag, " data_out"},   data_out,   d);
        chk({tag, " data_valid"}, {39'd0, data_valid}, {39'd0, dv});
        chk({tag, " busy"},       {39'd0, busy},       {39'd0, bz});
        chk({tag, " resync"},     {39'd0, resync},     {39'd0, rs});
    endtask

    initial begin
        rst         = 1'b1;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 40'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 1: spaced bytes
        add_word({8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 2, 40'h0, 40'h1122334455);
        add(1'b0, 8'h00, 1'b0, 40'h1122334455, 1'b0, 1'b0, 1'b0);
        // Test 2: back-to-back words
        add_word({8'h9a, 8'h78, 8'h56, 8'h34, 8'h12}, 0, 40'h1122334455, 40'h123456789a);
        add_word({8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 0, 40'h123456789a, 40'h0504030201);
        add(1'b0, 8'h00, 1'b0, 40'h0504030201, 1'b0, 1'b0, 1'b0);
        // Test 4: frame error with a byte mid-word, then idle frame-error cases
        add(1'b1, 8'h55, 1'b0, 40'h0504030201, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h44, 1'b0, 40'h0504030201, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h33, 1'b0, 40'h0504030201, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h22, 1'b1, 40'h0504030201, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 40'h0504030201, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 40'h0504030201, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'h77, 1'b1, 40'h0504030201, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 40'h0504030201, 1'b0, 1'b0, 1'b0);
        add_word({8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, 40'h0504030201, 40'h5544332211);
        add(1'b0, 8'h00, 1'b0, 40'h5544332211, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].b, vecs[i].fe);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_dv,
                    vecs[i].exp_busy, vecs[i].exp_rs);
        end

        // Test 3: gap timeout fires on the 16th idle edge after the last byte
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 8'h00, 1'b0);
            chk_all($sformatf("timeout k%0d", k), 40'h5544332211, 1'b0,
                    (k < 16), (k == 16));
        end
        step(1'b1, 8'haa, 1'b0);
        step(1'b1, 8'hbb, 1'b0);
        step(1'b1, 8'hcc, 1'b0);
        step(1'b1, 8'hdd, 1'b0);
        step(1'b1, 8'hee, 1'b0);
        chk_all("after timeout word", 40'heeddccbbaa, 1'b1, 1'b0, 1'b0);

        // Test 6: byte on the cycle the gap count sits at 15 wins over expiry
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        for (int k = 1; k <= 15; k++) step(1'b0, 8'h00, 1'b0);
        chk_all("gap at 15", 40'heeddccbbaa, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk_all("byte wins expiry", 40'heeddccbbaa, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        chk_all("late word done", 40'h1122334455, 1'b1, 1'b0, 1'b0);

        // Test 5: asynchronous reset mid-word
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async reset", 40'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'ha1, 1'b0);
        step(1'b1, 8'hb2, 1'b0);
        step(1'b1, 8'hc3, 1'b0);
        step(1'b1, 8'hd4, 1'b0);
        chk_all("post reset partial", 40'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'he5, 1'b0);
        chk_all("post reset word", 40'he5d4c3b2a1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk_all("post reset idle", 40'he5d4c3b2a1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
